// File: rtl/morse_pkg.sv
// Shared definitions for the SOS Morse receive path: element codes, FSM
// state encoding, the SOS reference pattern and default timing thresholds.
package morse_pkg;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    GAP  = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam logic [8:0] SOS_PATTERN = 9'b000_111_000;
  localparam logic [4:0] SOS_LEN     = 5'd9;

  // Defaults for a 50 MHz system clock; durations in 1 ms units.
  localparam logic [15:0] T1MS_DEF         = 16'd49_999;
  localparam logic [9:0]  MIN_MARK_MS_DEF  = 10'd30;
  localparam logic [9:0]  DASH_MIN_MS_DEF  = 10'd200;
  localparam logic [9:0]  DASH_MAX_MS_DEF  = 10'd600;
  localparam logic [9:0]  FRAME_GAP_MS_DEF = 10'd150;
  localparam logic [9:0]  GLITCH_MS_DEF    = 10'd8;

endpackage

// File: rtl/morse_ms_timer.sv
// Millisecond timer: prescaler producing a 1 ms tick and a 10-bit ms count
// that saturates at 1023. A synchronous clear restarts both, and wins over a
// tick that lands in the same cycle.
module morse_ms_timer #(
  parameter logic [15:0] T1MS = 16'd49_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic [9:0] count_ms
);

  logic [15:0] presc;

  // Prescaler and saturating ms counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc    <= '0;
      count_ms <= '0;
    end else if (presc == T1MS) begin
      presc <= '0;
      if (count_ms != 10'd1023) count_ms <= count_ms + 10'd1;
    end else begin
      presc <= presc + 16'd1;
    end
  end

endmodule

// File: rtl/sos_morse_decoder.sv
// SOS Morse decoder: synchronizes an active-low key line, times marks and
// gaps in ms, classifies marks as dot/dash/error and emits a frame after a
// long released gap, flagging frames that spell S-O-S.
// Optional glitch filter on the synchronized line: MORSE_GLITCH_FILTER_EN.
//
// state | meaning
// IDLE  | line released, no frame in progress
// MARK  | line held (tone on), timing the mark
// GAP   | line released inside a frame, timing the gap
// EMIT  | frame outputs presented for one cycle, frame storage cleared
module sos_morse_decoder
  import morse_pkg::*;
#(
  parameter logic [15:0] T1MS         = T1MS_DEF,
  parameter logic [9:0]  MIN_MARK_MS  = MIN_MARK_MS_DEF,
  parameter logic [9:0]  DASH_MIN_MS  = DASH_MIN_MS_DEF,
  parameter logic [9:0]  DASH_MAX_MS  = DASH_MAX_MS_DEF,
  parameter logic [9:0]  FRAME_GAP_MS = FRAME_GAP_MS_DEF
`ifdef MORSE_GLITCH_FILTER_EN
  , parameter logic [9:0] GLITCH_MS   = GLITCH_MS_DEF
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Key_In,
  output logic        Frame_Valid,
  output logic [15:0] Frame_Bits,
  output logic [4:0]  Frame_Len,
  output logic        Frame_Err,
  output logic        SOS_Det
);

  logic       sync1, key_s, key_f, key_d;
  logic       fall, rise;
  logic [9:0] count_ms;

  state_t      state, state_nx;
  logic [15:0] bits;
  logic [4:0]  len;
  logic        err_f;
  logic        append, elem, set_err, emit, clear;
  logic        sos_match;

  // Two-flop synchronizer; idles at released (1).
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b1;
      key_s <= 1'b1;
    end else begin
      sync1 <= Key_In;
      key_s <= sync1;
    end
  end

`ifdef MORSE_GLITCH_FILTER_EN
  logic [9:0] glitch_ms;
  logic       key_f_r;

  // The filter timer runs only while the synchronized level disagrees with
  // the accepted level, so any shorter excursion restarts it.
  morse_ms_timer #(.T1MS(T1MS)) u_glitch_timer (
    .clk      (CLK),
    .rst      (RST),
    .clr      (key_s == key_f_r),
    .count_ms (glitch_ms)
  );

  // Accept the new level once it has been stable for GLITCH_MS ticks.
  always_ff @(posedge CLK) begin
    if (RST) key_f_r <= 1'b1;
    else if ((key_s != key_f_r) && (glitch_ms == GLITCH_MS)) key_f_r <= key_s;
  end

  assign key_f = key_f_r;
`else
  assign key_f = key_s;
`endif

  // Previous filtered level for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) key_d <= 1'b1;
    else     key_d <= key_f;
  end

  assign fall = key_d & ~key_f;
  assign rise = ~key_d & key_f;

  morse_ms_timer #(.T1MS(T1MS)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .clr      (fall | rise),
    .count_ms (count_ms)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and datapath strobes; marks are classified on the count
  // value still present in the release-edge cycle.
  always_comb begin
    state_nx = state;
    append   = 1'b0;
    elem     = DOT;
    set_err  = 1'b0;
    emit     = 1'b0;
    clear    = 1'b0;
    unique case (state)
      IDLE: if (fall) state_nx = MARK;
      MARK: begin
        if (rise) begin
          if ((count_ms < MIN_MARK_MS) || (count_ms > DASH_MAX_MS)) begin
            set_err = 1'b1;
          end else begin
            append = 1'b1;
            elem   = (count_ms < DASH_MIN_MS) ? DOT : DASH;
          end
          state_nx = GAP;
        end
      end
      GAP: begin
        if (fall) begin
          state_nx = MARK;
        end else if (count_ms == FRAME_GAP_MS) begin
          emit     = 1'b1;
          state_nx = EMIT;
        end
      end
      EMIT: begin
        clear    = 1'b1;
        state_nx = fall ? MARK : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Element shift register, length and error flag; a 17th element is
  // dropped and marks the frame as overflowed.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      bits  <= '0;
      len   <= '0;
      err_f <= 1'b0;
    end else begin
      if (set_err) err_f <= 1'b1;
      if (append) begin
        if (len == 5'd16) begin
          err_f <= 1'b1;
        end else begin
          bits <= {bits[14:0], elem};
          len  <= len + 5'd1;
        end
      end
    end
  end

  assign sos_match = (len == SOS_LEN) && (bits[8:0] == SOS_PATTERN) && !err_f;

  // Frame outputs load on the way into EMIT so they are visible during it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Frame_Valid <= 1'b0;
      SOS_Det     <= 1'b0;
      Frame_Bits  <= '0;
      Frame_Len   <= '0;
      Frame_Err   <= 1'b0;
    end else begin
      Frame_Valid <= emit;
      SOS_Det     <= emit && sos_match;
      if (emit) begin
        Frame_Bits <= bits;
        Frame_Len  <= len;
        Frame_Err  <= err_f;
      end
    end
  end

endmodule

// File: tb/tb_sos_morse_decoder.sv
// Self-checking bench for sos_morse_decoder. The prescaler is shortened so a
// "ms" is P clock cycles; all durations below are in those units.
`timescale 1ns/1ps
module tb_sos_morse_decoder;

  localparam logic [15:0] T1 = 16'd1;
  localparam int P = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Key_In;
  logic        Frame_Valid, Frame_Err, SOS_Det;
  logic [15:0] Frame_Bits;
  logic [4:0]  Frame_Len;

  sos_morse_decoder #(.T1MS(T1)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Key_In     (Key_In),
    .Frame_Valid(Frame_Valid),
    .Frame_Bits (Frame_Bits),
    .Frame_Len  (Frame_Len),
    .Frame_Err  (Frame_Err),
    .SOS_Det    (SOS_Det)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] bits;
    logic [4:0]  len;
    logic        err;
    logic        sos;
    int          at;
  } frame_t;

  typedef struct {
    string       name;
    string       pat;
    int          single_ms;
    logic [15:0] bits;
    logic [4:0]  len;
    logic        err;
    logic        sos;
  } vec_t;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     rel_cyc = 0;
  int     last_at = 0;
  frame_t fq[$];
  int     mk[$];
  int     gp[$];
  vec_t   tbl[10];

  always @(posedge CLK) cyc = cyc + 1;

  // Frame monitor, sampled on the falling edge.
  always @(negedge CLK)
    if (Frame_Valid) fq.push_back('{Frame_Bits, Frame_Len, Frame_Err, SOS_Det, cyc});

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int n);
    Key_In = lvl;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive the queued marks; gp[i] is the released time after mark i.
  task automatic send();
    for (int i = 0; i < mk.size(); i++) begin
      hold(1'b0, mk[i]);
      rel_cyc = cyc;
      hold(1'b1, gp[i]);
    end
    mk.delete();
    gp.delete();
  endtask

  task automatic queue_pattern(input string s, input int end_gap);
    for (int i = 0; i < s.len(); i++) begin
      mk.push_back((s[i] == "-") ? 300 * P : 100 * P);
      gp.push_back((i == s.len() - 1) ? end_gap : 50 * P);
    end
  endtask

  task automatic check_frame(input string nm, input logic [15:0] eb, input logic [4:0] el,
                             input logic ee, input logic es);
    frame_t f;
    chk({nm, "_frames"}, fq.size(), 1);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      last_at = f.at;
      chk({nm, "_bits"}, f.bits, eb);
      chk({nm, "_len"},  f.len,  el);
      chk({nm, "_err"},  f.err,  ee);
      chk({nm, "_sos"},  f.sos,  es);
    end
    fq.delete();
  endtask

  // Reference model: measured ms is the number of whole ms elapsed after the
  // edge cycle; classification and packing follow the frame rules directly.
  int          n_el, r, lo, hi, d, cnt;
  int          elems[$];
  logic        m_err;
  logic [15:0] m_bits;
  logic        m_sos;
  string       s;

  initial begin
    tbl[0] = '{"sos",       "...---...",         0, 16'h0038, 5'd9,  1'b0, 1'b1};
    tbl[1] = '{"dot_dash",  ".-",                0, 16'h0001, 5'd2,  1'b0, 1'b0};
    tbl[2] = '{"mark29",    "",                 29, 16'h0000, 5'd0,  1'b1, 1'b0};
    tbl[3] = '{"mark199",   "",                199, 16'h0000, 5'd1,  1'b0, 1'b0};
    tbl[4] = '{"mark200",   "",                200, 16'h0001, 5'd1,  1'b0, 1'b0};
    tbl[5] = '{"mark600",   "",                600, 16'h0001, 5'd1,  1'b0, 1'b0};
    tbl[6] = '{"mark601",   "",                601, 16'h0000, 5'd0,  1'b1, 1'b0};
    tbl[7] = '{"overflow",  ".................", 0, 16'h0000, 5'd16, 1'b1, 1'b0};
    tbl[8] = '{"three_dash","---",               0, 16'h0007, 5'd3,  1'b0, 1'b0};
    tbl[9] = '{"near_sos",  "...---..-",         0, 16'h0039, 5'd9,  1'b0, 1'b0};

    Key_In = 1'b1;
    RST    = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    chk("rst_valid", Frame_Valid, 0);
    chk("rst_bits",  Frame_Bits,  0);
    chk("rst_len",   Frame_Len,   0);
    chk("rst_err",   Frame_Err,   0);
    chk("rst_sos",   SOS_Det,     0);
    RST = 1'b0;
    hold(1'b1, 20 * P);

    // Table-driven frames.
    for (int k = 0; k < 10; k++) begin
      s = tbl[k].pat;
      if (s.len() == 0) begin
        mk.push_back(tbl[k].single_ms * P + 1);
        gp.push_back(200 * P);
      end else begin
        queue_pattern(s, 200 * P);
      end
      send();
      check_frame(tbl[k].name, tbl[k].bits, tbl[k].len, tbl[k].err, tbl[k].sos);
      if (k == 0)
        chk("sos_gap_latency", (last_at - rel_cyc >= 150 * P) && (last_at - rel_cyc <= 150 * P + 8), 1);
      chk({tbl[k].name, "_hold_len"}, Frame_Len, tbl[k].len);
      chk({tbl[k].name, "_valid_low"}, Frame_Valid, 0);
    end

    // Reset during the 5th element discards the partial frame.
    queue_pattern("....", 50 * P);
    send();
    hold(1'b0, 150 * P);
    RST = 1'b1;
    hold(1'b0, 3);
    hold(1'b1, 5);
    RST = 1'b0;
    hold(1'b1, 200 * P);
    chk("rst_mid_no_frame", fq.size(), 0);
    queue_pattern("...---...", 200 * P);
    send();
    check_frame("rst_then_sos", 16'h0038, 5'd9, 1'b0, 1'b1);

    // Short low glitches splitting each intra-frame gap.
    s = "...---...";
    for (int i = 0; i < 9; i++) begin
      hold(1'b0, (s[i] == "-") ? 300 * P : 100 * P);
      if (i < 8) begin
        hold(1'b1, 20 * P);
        hold(1'b0, 2 * P);
        hold(1'b1, 28 * P);
      end else begin
        hold(1'b1, 200 * P);
      end
    end
`ifdef MORSE_GLITCH_FILTER_EN
    check_frame("glitch_sos", 16'h0038, 5'd9, 1'b0, 1'b1);
`else
    check_frame("glitch_sos", 16'h0038, 5'd9, 1'b1, 1'b0);
`endif

    // Randomized frames against the reference model.
    for (int f = 0; f < 6; f++) begin
      n_el = $urandom_range(1, 9);
      elems.delete();
      m_err = 1'b0;
      for (int i = 0; i < n_el; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      begin lo = 12;  hi = 25;  end
        else if (r == 1) begin lo = 605; hi = 680; end
        else if (r < 6)  begin lo = 35;  hi = 190; end
        else             begin lo = 210; hi = 400; end
        cnt = $urandom_range(lo * P, hi * P);
        mk.push_back(cnt);
        gp.push_back((i == n_el - 1) ? $urandom_range(180 * P, 230 * P)
                                     : $urandom_range(30 * P, 100 * P));
        d = (cnt - 1) / P;
        if (d < 30 || d > 600) m_err = 1'b1;
        else if (elems.size() == 16) m_err = 1'b1;
        else elems.push_back((d < 200) ? 0 : 1);
      end
      m_bits = 16'h0000;
      for (int i = 0; i < elems.size(); i++) m_bits = m_bits * 2 + 16'(elems[i]);
      m_sos = (elems.size() == 9) && (m_bits == 16'h0038) && !m_err;
      send();
      check_frame($sformatf("rand%0d", f), m_bits, 5'(elems.size()), m_err, m_sos);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sos_morse_decoder.md
# sos_morse_decoder

Receive-side counterpart of the SOS buzzer sequencer. Samples an active-low Morse key/tone line, times marks and gaps in 1 ms units, classifies each mark as dot or dash, and packs elements into a frame that closes after a long gap. Flags a completed frame matching S-O-S (`...---...`). Sits between a board key/tone-detector pin and the status/LED logic.

## Interface
- `T1MS`, 16'd49_999: prescaler terminal count for 1 ms at 50 MHz.
- `MIN_MARK_MS`, 30: marks shorter than this are errors.
- `DASH_MIN_MS`, 200: marks of at least this length are dashes; shorter marks are dots.
- `DASH_MAX_MS`, 600: marks longer than this are errors.
- `FRAME_GAP_MS`, 150: a released-line gap of this length closes the frame.
- `GLITCH_MS`, 8: stability window, used only when `MORSE_GLITCH_FILTER_EN` is defined.
- `CLK`  in  1: system clock.
- `RST`  in  1: synchronous reset, active-high.
- `Key_In`  in  1: asynchronous Morse line; 0 = mark (tone on), 1 = released.
- `Frame_Valid`  out  1: one-cycle pulse when a frame closes.
- `Frame_Bits`  out  16: elements, 0 = dot, 1 = dash; first element at bit `Frame_Len-1`, last at bit 0; upper bits 0.
- `Frame_Len`  out  5: number of elements, 0–16.
- `Frame_Err`  out  1: frame contained an out-of-range mark or overflow.
- `SOS_Det`  out  1: one-cycle pulse with `Frame_Valid` when the frame is a valid SOS.

## Operation
- Reset values:
  - All outputs 0.
  - Synchronizer flops 1 (released).
  - State IDLE; element shift register, length and error flag cleared.
- `Key_In` passes through a 2-flop synchronizer to give `key_s`. The filtered level `key_f` derives from `key_s` (see Configuration).
- Timer:
  - The 16-bit prescaler and 10-bit `count_MS` both clear on every `key_f` edge.
  - `count_MS` increments when the prescaler equals `T1MS` and saturates at 1023.
- State machine:
  - IDLE: on `key_f` falling edge, go to MARK.
  - MARK: on `key_f` rising edge, classify `d = count_MS`:
    - `d < MIN_MARK_MS` or `d > DASH_MAX_MS` (including saturated 1023): set the error flag and append no element.
    - `d < DASH_MIN_MS`: append 0.
    - Otherwise: append 1.
    - Then go to GAP.
  - Append rule: `bits <= {bits[14:0], elem}` and `len <= len + 1`. If `len == 16`, append nothing and set the error flag.
  - GAP:
    - On `key_f` falling edge, go to MARK; the gap was intra-frame.
    - When `count_MS == FRAME_GAP_MS`, go to EMIT.
  - EMIT (one cycle):
    - Register `Frame_Bits`, `Frame_Len` and `Frame_Err`.
    - Pulse `Frame_Valid`.
    - Pulse `SOS_Det` iff `len == 9`, `bits[8:0] == 9'b000_111_000` and the error flag is clear.
    - Clear the shift register, length and flag; go to IDLE.
- A frame made only of rejected marks is still emitted, with `Frame_Len = 0` and `Frame_Err = 1`.
- `Frame_Bits`, `Frame_Len` and `Frame_Err` hold until the next EMIT.

## Timing
- Mark/gap measurement resolution is ±1 ms.
- If an edge and a tick coincide in one cycle, the edge wins: the counter clears and the tick is dropped.
- Classification uses `count_MS` before clearing, in the edge cycle.
- `Frame_Valid` asserts exactly 1 cycle after `count_MS` reaches `FRAME_GAP_MS`.
- Latency from `Key_In` to `key_s` is 2 cycles, plus the filter delay when the filter is enabled.
- Reset mid-frame discards the partial frame; no `Frame_Valid` is produced.
- A line held low forever never emits. On release the mark is classified as an error.

## Configuration
- `MORSE_GLITCH_FILTER_EN` defined:
  - `key_f` changes only after `key_s` has differed from `key_f` for `GLITCH_MS` consecutive ms ticks.
  - Both edges are delayed equally, so measured durations are unchanged.
  - Pulses shorter than `GLITCH_MS` are invisible.
- Not defined: `key_f = key_s`; the filter counter is not synthesized.

## Structure
- Package `morse_pkg`:
  - Element codes `DOT = 1'b0`, `DASH = 1'b1`.
  - State encoding IDLE/MARK/GAP/EMIT.
  - `SOS_PATTERN = 9'b000_111_000` and `SOS_LEN = 9`.
  - Default threshold constants.
- Sub-module `morse_ms_timer`: prescaler plus saturating `count_MS` with synchronous clear input. It is reused by the glitch filter when that filter is enabled.

## Test plan
- Drive the encoder timing (100 ms dot, 300 ms dash, 50 ms gaps, then idle) -> one `Frame_Valid` about 150 ms after the last release, with `Frame_Len = 9`, `Frame_Bits = 16'h0038`, `Frame_Err = 0` and `SOS_Det = 1`.
- Send `.-` then a 200 ms gap -> `Frame_Len = 2`, `Frame_Bits = 16'h0001`, `SOS_Det = 0`.
- Marks of 29, 199, 200, 600 and 601 ms in separate frames -> err; dot; dash; dash; err (err frames `Frame_Len = 0`).
- Send 17 dots with 50 ms gaps -> `Frame_Len = 16`, `Frame_Bits = 16'h0000`, `Frame_Err = 1`.
- Assert `RST` during the 5th element of an SOS, then send a full SOS -> exactly one `Frame_Valid` (the second SOS), with `SOS_Det = 1`.
- With the macro defined: inject 2 ms low glitches into the gaps of an SOS -> same result as the first case. Without the macro, the same stimulus -> `Frame_Err = 1`.
